// File: rtl/prog_down_timer.sv
// prog_down_timer: programmable down-counting timer, one-shot/periodic; optional prescaler via `PRESC_EN
module prog_down_timer #(
  parameter int N     = 16,
  parameter int PRESC = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  output logic [N-1:0] q,
  output logic         zero_tick,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t state_q, state_d;
  logic [N-1:0] q_q, q_d, rl_q, rl_d;
  logic mode_q, mode_d, zt_q, zt_d, busy_q, done_q;
  logic tick;
`ifdef PRESC_EN
  localparam int PW = $clog2(PRESC) + 1;
  logic [PW-1:0] pc_q, pc_d;
  assign tick = (state_q == RUN) && (pc_q == PW'(PRESC - 1));
  // prescaler advances only while counting undisturbed; any restart or tick clears it
  always_comb begin
    pc_d = (state_q == RUN && !tick && !syn_clr && !stop && !start) ? pc_q + 1'b1 : '0;
  end
  // prescaler register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end
`else
  assign tick = (state_q == RUN);
`endif
  // next-state: syn_clr > stop > start > count, load in parallel
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    mode_d  = mode_q;
    zt_d    = 1'b0;
    rl_d    = load ? d : rl_q;
    if (syn_clr) begin
      q_d     = '0;
      state_d = IDLE;
    end else if (stop && state_q == RUN) begin
      state_d = IDLE;
    end else if (start) begin
      mode_d  = periodic;
      q_d     = rl_q;
      state_d = (rl_q == '0) ? EXPIRED : RUN;
      zt_d    = (rl_q == '0);
    end else if (tick) begin
      if (q_q > N'(1)) begin
        q_d = q_q - 1'b1;
      end else if (mode_q) begin
        q_d  = rl_q;
        zt_d = 1'b1;
      end else begin
        q_d     = '0;
        state_d = EXPIRED;
        zt_d    = 1'b1;
      end
    end else if (load && state_q != RUN) begin
      q_d = d;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      rl_q    <= '0;
      mode_q  <= 1'b0;
      zt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rl_q    <= rl_d;
      mode_q  <= mode_d;
      zt_q    <= zt_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == EXPIRED);
    end
  end
  assign q         = q_q;
  assign zero_tick = zt_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule
